// File: rtl/hazard_unit_sb_if.sv
// Bundle of all hazard-unit signals exchanged with the datapath.
// The slave modport is the hazard unit, the master modport is the datapath.
// The HAZARD_PERF_EN macro adds the 32-bit performance counter outputs.
interface hazard_unit_sb_if #(
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = 5,
  parameter int NUM_FWD  = 3,
  parameter int MAX_PEND = 4
);
  localparam int SELW = $clog2(NUM_FWD + 1);
  localparam int CNTW = $clog2(MAX_PEND + 1);

  logic                      i_cache_stall;
  logic                      d_cache_stall;
  logic                      alu_stallE;
  logic                      flush_exceptionM;
  logic                      flush_pred_failedM;
  logic                      flush_jump_conflictE;
  logic [NUM_SRC-1:0]        src_validD;
  logic [NUM_SRC*REG_AW-1:0] src_addrD;
  logic [NUM_FWD-1:0]        fwd_we;
  logic [NUM_FWD*REG_AW-1:0] fwd_waddr;
  logic [NUM_FWD-1:0]        fwd_ready;
  logic                      lop_issueE;
  logic [REG_AW-1:0]         lop_waddrE;
  logic                      lop_needD;
  logic                      lop_done;
  logic [REG_AW-1:0]         lop_done_addr;

  logic stallF, stallD, stallE, stallM, stallW;
  logic flushF, flushD, flushE, flushM, flushW;
  logic [NUM_SRC*SELW-1:0]   fwd_sel;
  logic                      exc_drain;
  logic [CNTW-1:0]           pend_cnt;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_mem_cyc, perf_use_cyc, perf_sb_cyc, perf_flush_cnt;

  modport slave (
    input  i_cache_stall, d_cache_stall, alu_stallE, flush_exceptionM,
           flush_pred_failedM, flush_jump_conflictE, src_validD, src_addrD,
           fwd_we, fwd_waddr, fwd_ready, lop_issueE, lop_waddrE, lop_needD,
           lop_done, lop_done_addr,
    output stallF, stallD, stallE, stallM, stallW,
           flushF, flushD, flushE, flushM, flushW,
           fwd_sel, exc_drain, pend_cnt,
           perf_mem_cyc, perf_use_cyc, perf_sb_cyc, perf_flush_cnt
  );
  modport master (
    output i_cache_stall, d_cache_stall, alu_stallE, flush_exceptionM,
           flush_pred_failedM, flush_jump_conflictE, src_validD, src_addrD,
           fwd_we, fwd_waddr, fwd_ready, lop_issueE, lop_waddrE, lop_needD,
           lop_done, lop_done_addr,
    input  stallF, stallD, stallE, stallM, stallW,
           flushF, flushD, flushE, flushM, flushW,
           fwd_sel, exc_drain, pend_cnt,
           perf_mem_cyc, perf_use_cyc, perf_sb_cyc, perf_flush_cnt
  );
`else
  modport slave (
    input  i_cache_stall, d_cache_stall, alu_stallE, flush_exceptionM,
           flush_pred_failedM, flush_jump_conflictE, src_validD, src_addrD,
           fwd_we, fwd_waddr, fwd_ready, lop_issueE, lop_waddrE, lop_needD,
           lop_done, lop_done_addr,
    output stallF, stallD, stallE, stallM, stallW,
           flushF, flushD, flushE, flushM, flushW,
           fwd_sel, exc_drain, pend_cnt
  );
  modport master (
    output i_cache_stall, d_cache_stall, alu_stallE, flush_exceptionM,
           flush_pred_failedM, flush_jump_conflictE, src_validD, src_addrD,
           fwd_we, fwd_waddr, fwd_ready, lop_issueE, lop_waddrE, lop_needD,
           lop_done, lop_done_addr,
    input  stallF, stallD, stallE, stallM, stallW,
           flushF, flushD, flushE, flushM, flushW,
           fwd_sel, exc_drain, pend_cnt
  );
`endif
endinterface

// File: rtl/hazard_unit_sb.sv
// Stall/flush/forwarding control for the 5-stage core with a long-latency
// scoreboard and an exception-drain FSM for exceptions raised during a miss.
// Optional macro HAZARD_PERF_EN adds mem/use/scoreboard stall cycle counters
// and a flushD rising-edge counter.
module hazard_unit_sb #(
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = 5,
  parameter int NUM_FWD  = 3,
  parameter int MAX_PEND = 4
) (
  input logic             clk,
  input logic             resetn,
  hazard_unit_sb_if.slave hz
);
  localparam int SELW = $clog2(NUM_FWD + 1);
  localparam int CNTW = $clog2(MAX_PEND + 1);
  localparam int NREG = 2 ** REG_AW;
  localparam logic [CNTW-1:0] MAX_CNT = CNTW'(MAX_PEND);
  localparam logic [CNTW-1:0] ONE_CNT = CNTW'(1);

  typedef enum logic {RUN, DRAIN} drainState_t;

  drainState_t             state, stateNext;
  logic [NREG-1:0]         sbBits, sbNext;
  logic [CNTW-1:0]         pendCnt, cntNext;
  logic [REG_AW-1:0]       srcAddr [NUM_SRC];
  logic [REG_AW-1:0]       fwdAddr [NUM_FWD];
  logic [NUM_SRC*SELW-1:0] fwdSel;
  logic                    mem, useStall, sbStall, dStall, excDrain;
  logic                    stallDInt, stallEInt, flushDInt;
  logic                    issueOk, doneOk, sameAddr;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign srcAddr[i] = hz.src_addrD[i*REG_AW +: REG_AW];
  end
  for (genvar k = 0; k < NUM_FWD; k++) begin : g_fwd
    assign fwdAddr[k] = hz.fwd_waddr[k*REG_AW +: REG_AW];
  end

  // Forwarding select (youngest matching stage wins) plus use and scoreboard stalls.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    fwdSel   = '0;
    useStall = 1'b0;
    sbStall  = hz.lop_needD && (pendCnt == MAX_CNT);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (hz.src_validD[i] && (srcAddr[i] != '0)) begin
        // Oldest first so the youngest match overwrites it.
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
          if (hz.fwd_we[k] && (fwdAddr[k] == srcAddr[i])) begin
            fwdSel[i*SELW +: SELW] = SELW'(k + 1);
          end
        end
        for (int k = 0; k < NUM_FWD; k++) begin
          if ((fwdSel[i*SELW +: SELW] == SELW'(k + 1)) && !hz.fwd_ready[k]) begin
            useStall = 1'b1;
          end
        end
        // Registered bits only: a same-cycle lop_done does not release the stall.
        if (sbBits[srcAddr[i]]) sbStall = 1'b1;
      end
    end
  end

  // Scoreboard next state: done before issue so a same-address pair keeps the bit.
  always_comb begin
    issueOk  = hz.lop_issueE && (hz.lop_waddrE != '0) && (pendCnt != MAX_CNT);
    doneOk   = hz.lop_done && sbBits[hz.lop_done_addr] && (pendCnt != '0);
    sameAddr = issueOk && doneOk && (hz.lop_waddrE == hz.lop_done_addr);
    sbNext   = sbBits;
    cntNext  = pendCnt;
    if (!sameAddr) begin
      if (doneOk) begin
        sbNext[hz.lop_done_addr] = 1'b0;
        cntNext = cntNext - ONE_CNT;
      end
      if (issueOk) begin
        sbNext[hz.lop_waddrE] = 1'b1;
        cntNext = cntNext + ONE_CNT;
      end
    end
  end

  // Scoreboard register; an exception wipes every pending write.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: the pending-bit array is reset like any flop because a stale bit
    // would stall D forever; it is small enough to live in flops.
    if (!resetn) begin
      sbBits  <= '0;
      pendCnt <= '0;
    end else if (hz.flush_exceptionM) begin
      sbBits  <= '0;
      pendCnt <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignment so every flop samples
      // the pre-edge values regardless of statement order.
      sbBits  <= sbNext;
      pendCnt <= cntNext;
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= RUN;
    else         state <= stateNext;
  end

  // Drain FSM next state and output.
  always_comb begin
    stateNext = state;
    excDrain  = (state == DRAIN);
    case (state)
      RUN:     if (hz.flush_exceptionM && mem) stateNext = DRAIN;
      DRAIN:   if (!mem) stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  assign mem       = hz.i_cache_stall | hz.d_cache_stall;
  assign dStall    = useStall | sbStall;
  assign stallDInt = mem | hz.alu_stallE | dStall;
  assign stallEInt = mem | hz.alu_stallE;
  assign flushDInt = hz.flush_exceptionM | excDrain | hz.flush_pred_failedM
                   | (hz.flush_jump_conflictE & ~stallDInt);

  assign hz.stallF = (~hz.flush_exceptionM & stallEInt) | dStall | excDrain;
  assign hz.stallD = stallDInt;
  assign hz.stallE = stallEInt;
  assign hz.stallM = mem;
  assign hz.stallW = ~hz.flush_exceptionM & mem & ~excDrain;
  assign hz.flushF = 1'b0;
  assign hz.flushD = flushDInt;
  assign hz.flushE = hz.flush_exceptionM | excDrain
                   | (hz.flush_pred_failedM & ~stallEInt) | (~stallEInt & dStall);
  assign hz.flushM = hz.flush_exceptionM | excDrain;
  assign hz.flushW = hz.flush_exceptionM;
  assign hz.fwd_sel   = fwdSel;
  assign hz.exc_drain = excDrain;
  assign hz.pend_cnt  = pendCnt;

`ifdef HAZARD_PERF_EN
  logic        flushDq;
  logic [31:0] memCyc, useCyc, sbCyc, flushCnt;

  // Free-running event counters; they wrap naturally at 2^32.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flushDq  <= 1'b0;
      memCyc   <= '0;
      useCyc   <= '0;
      sbCyc    <= '0;
      flushCnt <= '0;
    end else begin
      flushDq <= flushDInt;
      if (mem)                   memCyc   <= memCyc + 32'd1;
      if (useStall)              useCyc   <= useCyc + 32'd1;
      if (sbStall)               sbCyc    <= sbCyc + 32'd1;
      if (flushDInt && !flushDq) flushCnt <= flushCnt + 32'd1;
    end
  end

  assign hz.perf_mem_cyc   = memCyc;
  assign hz.perf_use_cyc   = useCyc;
  assign hz.perf_sb_cyc    = sbCyc;
  assign hz.perf_flush_cnt = flushCnt;
`endif
endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed bench for hazard_unit_sb: forwarding, load-use, scoreboard,
// exception drain and asynchronous reset, with hand-computed expectations.
module tb_hazard_unit_sb;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int testsRun = 0;
  int testsFailed = 0;

  hazard_unit_sb_if #(.NUM_SRC(2), .REG_AW(5), .NUM_FWD(3), .MAX_PEND(4)) hz ();
  hazard_unit_sb #(.NUM_SRC(2), .REG_AW(5), .NUM_FWD(3), .MAX_PEND(4)) dut (
    .clk(clk), .resetn(resetn), .hz(hz.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] stallVec();
    return {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.stallW};
  endfunction
  function automatic logic [4:0] flushVec();
    return {hz.flushF, hz.flushD, hz.flushE, hz.flushM, hz.flushW};
  endfunction

  task automatic clear_inputs();
    hz.i_cache_stall = 1'b0; hz.d_cache_stall = 1'b0; hz.alu_stallE = 1'b0;
    hz.flush_exceptionM = 1'b0; hz.flush_pred_failedM = 1'b0;
    hz.flush_jump_conflictE = 1'b0;
    hz.src_validD = '0; hz.src_addrD = '0;
    hz.fwd_we = '0; hz.fwd_waddr = '0; hz.fwd_ready = '0;
    hz.lop_issueE = 1'b0; hz.lop_waddrE = '0; hz.lop_needD = 1'b0;
    hz.lop_done = 1'b0; hz.lop_done_addr = '0;
  endtask

  task automatic set_src(input int i, input logic v, input logic [4:0] a);
    hz.src_validD[i] = v;
    hz.src_addrD[i*5 +: 5] = a;
  endtask

  task automatic set_fwd(input int k, input logic we, input logic [4:0] a, input logic rdy);
    hz.fwd_we[k] = we;
    hz.fwd_waddr[k*5 +: 5] = a;
    hz.fwd_ready[k] = rdy;
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 1'b0;
    #2;
    testsRun++; if (stallVec() !== 5'b0) begin testsFailed++; $display("FAIL reset_stalls: got %b exp 00000", stallVec()); end
    testsRun++; if (flushVec() !== 5'b0) begin testsFailed++; $display("FAIL reset_flushes: got %b exp 00000", flushVec()); end
    testsRun++; if ({hz.exc_drain, hz.fwd_sel, hz.pend_cnt} !== 8'b0) begin testsFailed++; $display("FAIL reset_misc: drain %b sel %b pend %0d exp all 0", hz.exc_drain, hz.fwd_sel, hz.pend_cnt); end
    @(negedge clk); resetn = 1'b1;
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    @(negedge clk); clear_inputs(); hz.d_cache_stall = 1'b1;
    @(negedge clk);
    @(negedge clk); hz.d_cache_stall = 1'b0; set_src(0, 1'b1, 5'd6); set_fwd(0, 1'b1, 5'd6, 1'b0);
    @(negedge clk); clear_inputs(); hz.flush_pred_failedM = 1'b1;
    @(negedge clk);
    @(negedge clk); clear_inputs(); #1;
    testsRun++; if (hz.perf_mem_cyc !== 32'd2) begin testsFailed++; $display("FAIL perf_mem: got %0d exp 2", hz.perf_mem_cyc); end
    testsRun++; if (hz.perf_use_cyc !== 32'd1) begin testsFailed++; $display("FAIL perf_use: got %0d exp 1", hz.perf_use_cyc); end
    testsRun++; if (hz.perf_sb_cyc !== 32'd0) begin testsFailed++; $display("FAIL perf_sb: got %0d exp 0", hz.perf_sb_cyc); end
    testsRun++; if (hz.perf_flush_cnt !== 32'd1) begin testsFailed++; $display("FAIL perf_flush: got %0d exp 1", hz.perf_flush_cnt); end
  endtask
`endif

  task automatic test_forwarding();
    @(negedge clk); clear_inputs();
    set_src(0, 1'b1, 5'd5);
    for (int k = 0; k < 3; k++) set_fwd(k, 1'b1, 5'd5, 1'b1);
    #1;
    testsRun++; if (hz.fwd_sel !== 4'b0001) begin testsFailed++; $display("FAIL fwd_all_match: got %b exp 0001", hz.fwd_sel); end
    testsRun++; if (stallVec() !== 5'b0) begin testsFailed++; $display("FAIL fwd_no_stall: got %b exp 00000", stallVec()); end
    @(negedge clk); hz.fwd_we = 3'b110; #1;
    testsRun++; if (hz.fwd_sel !== 4'b0010) begin testsFailed++; $display("FAIL fwd_m: got %b exp 0010", hz.fwd_sel); end
    @(negedge clk); hz.fwd_we = 3'b100; #1;
    testsRun++; if (hz.fwd_sel !== 4'b0011) begin testsFailed++; $display("FAIL fwd_w: got %b exp 0011", hz.fwd_sel); end
    @(negedge clk); hz.fwd_we = 3'b111; hz.fwd_waddr = '0; hz.fwd_ready = 3'b000; set_src(0, 1'b1, 5'd0); #1;
    testsRun++; if ({hz.fwd_sel, hz.stallD} !== 5'b0) begin testsFailed++; $display("FAIL fwd_r0: sel %b stallD %b exp 0000 0", hz.fwd_sel, hz.stallD); end
    @(negedge clk); hz.fwd_waddr = {5'd5, 5'd5, 5'd5}; set_src(0, 1'b0, 5'd5); #1;
    testsRun++; if ({hz.fwd_sel, hz.stallD} !== 5'b0) begin testsFailed++; $display("FAIL fwd_invalid: sel %b stallD %b exp 0000 0", hz.fwd_sel, hz.stallD); end
  endtask

  task automatic test_load_use();
    @(negedge clk); clear_inputs();
    set_src(1, 1'b1, 5'd7); set_fwd(0, 1'b1, 5'd7, 1'b0); #1;
    testsRun++; if (hz.fwd_sel !== 4'b0100) begin testsFailed++; $display("FAIL lu_sel: got %b exp 0100", hz.fwd_sel); end
    testsRun++; if (stallVec() !== 5'b11000) begin testsFailed++; $display("FAIL lu_stalls: got %b exp 11000", stallVec()); end
    testsRun++; if (flushVec() !== 5'b00100) begin testsFailed++; $display("FAIL lu_flushes: got %b exp 00100", flushVec()); end
    @(negedge clk); hz.d_cache_stall = 1'b1; #1;
    testsRun++; if ({stallVec(), flushVec()} !== 10'b11111_00000) begin testsFailed++; $display("FAIL lu_miss: stalls %b flushes %b exp 11111 00000", stallVec(), flushVec()); end
    @(negedge clk); hz.d_cache_stall = 1'b0; set_fwd(0, 1'b0, 5'd0, 1'b0); set_fwd(1, 1'b1, 5'd7, 1'b1); #1;
    testsRun++; if (hz.fwd_sel !== 4'b1000) begin testsFailed++; $display("FAIL lu_m_sel: got %b exp 1000", hz.fwd_sel); end
    testsRun++; if ({stallVec(), flushVec()} !== 10'b0) begin testsFailed++; $display("FAIL lu_m_clear: stalls %b flushes %b exp 0", stallVec(), flushVec()); end
  endtask

  task automatic issue_done(input logic iss, input logic [4:0] ia, input logic dn, input logic [4:0] da);
    @(negedge clk);
    hz.lop_issueE = iss; hz.lop_waddrE = ia; hz.lop_done = dn; hz.lop_done_addr = da;
    @(negedge clk);
    hz.lop_issueE = 1'b0; hz.lop_done = 1'b0;
  endtask

  task automatic test_scoreboard();
    @(negedge clk); clear_inputs();
    for (int r = 1; r <= 4; r++) begin
      @(negedge clk); hz.lop_issueE = 1'b1; hz.lop_waddrE = 5'(r);
    end
    @(negedge clk); hz.lop_issueE = 1'b0; #1;
    testsRun++; if (hz.pend_cnt !== 3'd4) begin testsFailed++; $display("FAIL sb_fill: got %0d exp 4", hz.pend_cnt); end
    issue_done(1'b1, 5'd5, 1'b0, 5'd0);
    set_src(0, 1'b1, 5'd5); #1;
    testsRun++; if ({hz.pend_cnt, hz.stallD} !== 4'b100_0) begin testsFailed++; $display("FAIL sb_full_issue: pend %0d stallD %b exp 4 0", hz.pend_cnt, hz.stallD); end
    @(negedge clk); set_src(0, 1'b0, 5'd0); hz.lop_needD = 1'b1; #1;
    testsRun++; if ({stallVec(), flushVec()} !== 10'b11000_00100) begin testsFailed++; $display("FAIL sb_need_full: stalls %b flushes %b exp 11000 00100", stallVec(), flushVec()); end
    @(negedge clk); hz.lop_needD = 1'b0; set_src(0, 1'b1, 5'd2);
    hz.lop_done = 1'b1; hz.lop_done_addr = 5'd2; #1;
    testsRun++; if (hz.stallD !== 1'b1) begin testsFailed++; $display("FAIL sb_no_bypass: got %b exp 1", hz.stallD); end
    @(negedge clk); hz.lop_done = 1'b0; #1;
    testsRun++; if ({hz.pend_cnt, hz.stallD} !== 4'b011_0) begin testsFailed++; $display("FAIL sb_done_r2: pend %0d stallD %b exp 3 0", hz.pend_cnt, hz.stallD); end
    issue_done(1'b0, 5'd0, 1'b1, 5'd2);
    #1;
    testsRun++; if (hz.pend_cnt !== 3'd3) begin testsFailed++; $display("FAIL sb_done_clear: got %0d exp 3", hz.pend_cnt); end
    issue_done(1'b0, 5'd0, 1'b1, 5'd1);
    issue_done(1'b1, 5'd9, 1'b0, 5'd0);
    issue_done(1'b1, 5'd9, 1'b1, 5'd9);
    set_src(0, 1'b1, 5'd9); #1;
    testsRun++; if ({hz.pend_cnt, hz.stallD} !== 4'b011_1) begin testsFailed++; $display("FAIL sb_same_addr: pend %0d stallD %b exp 3 1", hz.pend_cnt, hz.stallD); end
    issue_done(1'b1, 5'd10, 1'b1, 5'd3);
    set_src(0, 1'b1, 5'd3); #1;
    testsRun++; if ({hz.pend_cnt, hz.stallD} !== 4'b011_0) begin testsFailed++; $display("FAIL sb_diff_done: pend %0d stallD %b exp 3 0", hz.pend_cnt, hz.stallD); end
    @(negedge clk); set_src(0, 1'b1, 5'd10); #1;
    testsRun++; if (hz.stallD !== 1'b1) begin testsFailed++; $display("FAIL sb_diff_issue: got %b exp 1", hz.stallD); end
  endtask

  task automatic test_exception_drain();
    @(negedge clk); clear_inputs(); hz.d_cache_stall = 1'b1; hz.flush_exceptionM = 1'b1; #1;
    testsRun++; if ({stallVec(), flushVec()} !== 10'b01110_01111) begin testsFailed++; $display("FAIL exc_pulse: stalls %b flushes %b exp 01110 01111", stallVec(), flushVec()); end
    @(negedge clk); hz.flush_exceptionM = 1'b0; #1;
    testsRun++; if ({hz.exc_drain, hz.pend_cnt} !== 4'b1_000) begin testsFailed++; $display("FAIL drain_enter: drain %b pend %0d exp 1 0", hz.exc_drain, hz.pend_cnt); end
    testsRun++; if ({stallVec(), flushVec()} !== 10'b11110_01110) begin testsFailed++; $display("FAIL drain_ctrl: stalls %b flushes %b exp 11110 01110", stallVec(), flushVec()); end
    @(negedge clk); hz.flush_exceptionM = 1'b1;
    @(negedge clk); hz.flush_exceptionM = 1'b0; #1;
    testsRun++; if (hz.exc_drain !== 1'b1) begin testsFailed++; $display("FAIL drain_reexc: got %b exp 1", hz.exc_drain); end
    @(negedge clk); hz.d_cache_stall = 1'b0; #1;
    testsRun++; if ({hz.exc_drain, hz.stallW} !== 2'b10) begin testsFailed++; $display("FAIL drain_last: drain %b stallW %b exp 1 0", hz.exc_drain, hz.stallW); end
    @(negedge clk); set_src(0, 1'b1, 5'd9); #1;
    testsRun++; if ({hz.exc_drain, stallVec()} !== 6'b0) begin testsFailed++; $display("FAIL drain_exit: drain %b stalls %b exp 0 00000", hz.exc_drain, stallVec()); end
  endtask

  task automatic test_reset_mid_drain();
    @(negedge clk); clear_inputs(); hz.d_cache_stall = 1'b1; hz.flush_exceptionM = 1'b1;
    @(negedge clk); hz.flush_exceptionM = 1'b0; hz.lop_issueE = 1'b1; hz.lop_waddrE = 5'd3;
    @(negedge clk); hz.lop_issueE = 1'b0; #1;
    testsRun++; if ({hz.exc_drain, hz.pend_cnt} !== 4'b1_001) begin testsFailed++; $display("FAIL mid_pre: drain %b pend %0d exp 1 1", hz.exc_drain, hz.pend_cnt); end
    #1; resetn = 1'b0; #1;
    testsRun++; if ({hz.exc_drain, hz.pend_cnt} !== 4'b0) begin testsFailed++; $display("FAIL mid_async: drain %b pend %0d exp 0 0", hz.exc_drain, hz.pend_cnt); end
`ifdef HAZARD_PERF_EN
    testsRun++; if ({hz.perf_mem_cyc, hz.perf_use_cyc, hz.perf_sb_cyc, hz.perf_flush_cnt} !== 128'b0) begin testsFailed++; $display("FAIL mid_perf: mem %0d use %0d sb %0d flush %0d exp 0", hz.perf_mem_cyc, hz.perf_use_cyc, hz.perf_sb_cyc, hz.perf_flush_cnt); end
`endif
    @(negedge clk); resetn = 1'b1; clear_inputs();
    @(negedge clk); #1;
    testsRun++; if ({hz.exc_drain, stallVec(), flushVec()} !== 11'b0) begin testsFailed++; $display("FAIL mid_after: drain %b stalls %b flushes %b exp 0", hz.exc_drain, stallVec(), flushVec()); end
  endtask

  initial begin
    test_reset();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    test_forwarding();
    test_load_use();
    test_scoreboard();
    test_exception_drain();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule

// File: doc/hazard_unit_sb.md
Name: hazard_unit_sb

Overview:
Parametrised successor to the pipeline's stall/flush/forwarding control for the 5-stage core (F,D,E,M,W). The operand count, register address width and number of forwarding stages are generic, and each stage reports per-stage result readiness, which generalises load-use detection. It adds a sequential scoreboard for long-latency ops (mul/div) and an exception-drain FSM for exceptions that arrive during cache misses. It sits beside the datapath, is combinational for stall/flush/forwarding, and holds all of its state locally.

Parameters:
NUM_SRC, 2, number of D-stage source operands checked.
REG_AW, 5, register address width; address 0 never forwards or stalls.
NUM_FWD, 3, forwarding stages; index 0 = E (youngest), 1 = M, 2 = W.
MAX_PEND, 4, maximum outstanding long-latency writes (range 1..2^REG_AW-1).

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
i_cache_stall  in  1  I-cache miss stall
d_cache_stall  in  1  D-cache miss stall
alu_stallE  in  1  multicycle E-stage op busy
flush_exceptionM  in  1  exception commit in M
flush_pred_failedM  in  1  branch mispredict resolved in M
flush_jump_conflictE  in  1  jump redirect from E
src_validD  in  NUM_SRC  source i is read in D
src_addrD  in  NUM_SRC*REG_AW  source addresses, src i at [i*REG_AW +: REG_AW]
fwd_we  in  NUM_FWD  stage k writes a register
fwd_waddr  in  NUM_FWD*REG_AW  stage k destination address
fwd_ready  in  NUM_FWD  stage k result is already available (0 for load/mfc0/mfhilo in E)
lop_issueE  in  1  long-latency op leaves E this cycle
lop_waddrE  in  REG_AW  its destination address
lop_needD  in  1  D instruction is a long-latency op
lop_done  in  1  long-latency result written back
lop_done_addr  in  REG_AW  address completed
stallF, stallD, stallE, stallM, stallW  out  1 each  stage holds
flushF, flushD, flushE, flushM, flushW  out  1 each  stage bubbles
fwd_sel  out  NUM_SRC*SELW  per source: 0 = regfile, k+1 = stage k; SELW = $clog2(NUM_FWD+1)
exc_drain  out  1  exception drain in progress (fetch keeps redirect target)
pend_cnt  out  $clog2(MAX_PEND+1)  outstanding long-latency ops

Behaviour:
- Forwarding, per source: addr != 0 and valid; the youngest k with fwd_we[k] and an address match wins; otherwise 0.
- use_stall: some source selects stage k with fwd_ready[k] = 0.
- sb[]: 2^REG_AW pending bits. sb_stall: a valid nonzero source with sb[addr] = 1 (registered value only, so no same-cycle bypass of lop_done), or lop_needD and pend_cnt == MAX_PEND.
- mem = i_cache_stall | d_cache_stall. dstall = use_stall | sb_stall.
- stallF = (~flush_exceptionM & (mem | alu_stallE)) | dstall | exc_drain.
- stallD = mem | alu_stallE | dstall. stallE = mem | alu_stallE. stallM = mem.
- stallW = ~flush_exceptionM & mem & ~exc_drain.
- flushF = 0.
- flushD = flush_exceptionM | exc_drain | flush_pred_failedM | (flush_jump_conflictE & ~stallD).
- flushE = flush_exceptionM | exc_drain | (flush_pred_failedM & ~stallE) | (~stallE & dstall).
- flushM = flush_exceptionM | exc_drain. flushW = flush_exceptionM.
- Scoreboard update on posedge clk:
  - lop_issueE sets sb[lop_waddrE] (address 0 ignored) and increments pend_cnt.
  - lop_done clears sb[lop_done_addr] and decrements pend_cnt if that bit was set; a done on a clear bit is ignored.
  - Issue and done on the same address in one cycle: the bit stays set and pend_cnt is unchanged. Different addresses: both updates apply.
  - Issue while pend_cnt == MAX_PEND is ignored.
  - pend_cnt never wraps.
  - flush_exceptionM clears all bits and pend_cnt; this takes priority over issue and done in the same cycle.
- FSM, states RUN and DRAIN:
  - RUN to DRAIN when flush_exceptionM & mem.
  - DRAIN to RUN when mem = 0.
  - exc_drain = (state == DRAIN).
  - A new flush_exceptionM while in DRAIN stays in DRAIN.
- Reset (async, resetn = 0): state RUN, all sb bits 0, pend_cnt 0, performance counters 0. With all inputs at 0, every output is 0.
- Reset asserted mid-drain returns to RUN immediately.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds outputs perf_mem_cyc, perf_use_cyc, perf_sb_cyc, perf_flush_cnt, each 32 bits.
  - The first three count cycles with mem, use_stall or sb_stall asserted.
  - perf_flush_cnt counts rising edges of flushD.
  - All wrap at 2^32 and are cleared by resetn.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Forwarding priority: src0 = 5, fwd_we = 3'b111, all waddr = 5, fwd_ready = 3'b111 -> fwd_sel[src0] = 1, no stall. Same with src0 = 0 -> sel 0.
- Load-use: src1 = 7, E writes 7 with fwd_ready[0] = 0 -> stallF = stallD = 1, flushE = 1, stallE = 0. Next cycle, with M holding 7 ready -> sel = 2, stalls 0.
- Scoreboard fill: MAX_PEND = 4, issue to r1..r4 over 4 cycles -> pend_cnt = 4. Then lop_needD -> stallD = 1. lop_done r2 -> pend_cnt = 3. A src reading r2 the cycle after done does not stall.
- Same-cycle issue and done on r9 while sb[9] = 1 -> sb[9] stays 1, pend_cnt unchanged.
- Exception during miss: d_cache_stall = 1 and flush_exceptionM pulse -> exc_drain = 1 next cycle, flushD/E/M = 1, stallW = 0, sb cleared. Hold d_cache_stall 3 cycles, then deassert -> exc_drain = 0 the following cycle.
- Reset mid-drain: drop resetn during DRAIN -> exc_drain = 0 and pend_cnt = 0 asynchronously; with HAZARD_PERF_EN, all perf counters read 0.
